// File: rtl/demux_transiciones.sv
// Registered 1-to-4 transition demultiplexer: a rising edge on the data line is routed to a
// one-hot output selected at the edge and stretched to HOLDCYCLES clocks. Optional macro: DEMUX14_RETRIGGER_EN.
module demux_transiciones #(
  parameter int DEMUX14_SELECTWIDTH = 2,
  parameter int DEMUX14_DATAWIDTH   = 4,
  parameter int DEMUX14_HOLDCYCLES  = 4
) (
  input  logic                           CC_DEMUX14_CLOCK_50,
  input  logic                           CC_DEMUX14_RESET_InHigh,
  input  logic                           CC_DEMUX14_data_In,
  input  logic [DEMUX14_SELECTWIDTH-1:0] CC_DEMUX14_select_InBUS,
  output logic [DEMUX14_DATAWIDTH-1:0]   CC_DEMUX14_z_OutBUS,
  output logic                           CC_DEMUX14_busy_Out
);

  localparam int                CNT_W    = $clog2(DEMUX14_HOLDCYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEMUX14_HOLDCYCLES - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_data_prev;
  logic [DEMUX14_DATAWIDTH-1:0]   r_z;
  logic                           r_busy;

  logic                           w_event;
  logic                           w_accept;
  logic [DEMUX14_DATAWIDTH-1:0]   w_onehot;

  // Out-of-range selects fall onto the top output, like the selector's default arm.
  function automatic logic [DEMUX14_DATAWIDTH-1:0] f_route(
    input logic [DEMUX14_SELECTWIDTH-1:0] sel
  );
    logic [DEMUX14_DATAWIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEMUX14_DATAWIDTH; i++) begin
      if (int'(sel) == i) v[i] = 1'b1;
    end
    if (int'(sel) >= DEMUX14_DATAWIDTH) v[DEMUX14_DATAWIDTH-1] = 1'b1;
    return v;
  endfunction

  assign w_event  = CC_DEMUX14_data_In & ~r_data_prev;
  assign w_onehot = f_route(CC_DEMUX14_select_InBUS);

`ifdef DEMUX14_RETRIGGER_EN
  assign w_accept = w_event;
`else
  assign w_accept = w_event && (r_state == ST_IDLE);
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking; mixing in '=' would
  // make the result depend on statement order and simulation scheduling.
  always_ff @(posedge CC_DEMUX14_CLOCK_50 or posedge CC_DEMUX14_RESET_InHigh) begin
    if (CC_DEMUX14_RESET_InHigh) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_data_prev <= 1'b1;  // a line held high across reset release is not an event
      r_z         <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_data_prev <= CC_DEMUX14_data_In;
      if (w_accept) begin
        r_z     <= w_onehot;
        r_busy  <= 1'b1;
        r_cnt   <= CNT_LOAD;
        r_state <= ST_HOLD;
      end else if (r_state == ST_HOLD) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_z     <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign CC_DEMUX14_z_OutBUS = r_z;
  assign CC_DEMUX14_busy_Out = r_busy;

endmodule
